// File: rtl/frame_exchange_pkg.sv
// Shared types and helpers for the game/VGA frame exchange.
// Holds the overflow-policy enum, the occupancy state encoding and the modulo-depth pointer step.
package frame_exchange_pkg;

  typedef enum logic {FX_NEWEST, FX_HOLD} fx_mode_t;

  typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_state_t;

  localparam int FX_MAX_BUFFERS = 5;

  // The depth need not be a power of two, so the wrap is explicit.
  function automatic int unsigned fx_ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/frame_exchange_if.sv
// Producer/consumer handshake bundle for frame_exchange.
// The master side is the game encoder plus the VGA timing logic; the slave side is the exchange.
interface frame_exchange_if #(
  parameter int FRAME_BITS = 64
);
  logic                  GAME_new_frame_ready;
  logic [FRAME_BITS-1:0] GAME_next_frame;
  logic                  GAME_frame_accept;
  logic                  VGA_new_frame_ready;
  logic [FRAME_BITS-1:0] VGA_frame;
  logic                  VGA_frame_fresh;

  modport master (
    output GAME_new_frame_ready, GAME_next_frame, VGA_new_frame_ready,
    input  GAME_frame_accept, VGA_frame, VGA_frame_fresh
  );

  modport slave (
    input  GAME_new_frame_ready, GAME_next_frame, VGA_new_frame_ready,
    output GAME_frame_accept, VGA_frame, VGA_frame_fresh
  );
endinterface

// File: rtl/frame_exchange_ring.sv
// Circular frame store with read/write pointers, occupancy count and an EMPTY/PARTIAL/FULL tracker.
// Overwrite advances the read pointer alongside a push so the count stays put while the oldest frame is lost.
module frame_ring
  import frame_exchange_pkg::*;
#(
  parameter int FRAME_BITS = 64,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  overwrite_i,
  input  logic [FRAME_BITS-1:0] din_i,
  output logic [FRAME_BITS-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FRAME_BITS-1:0] slot_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  occ_state_t            state_q, state_d;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) slot_q[wr_ptr_q] <= din_i;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = PTR_W'(fx_ptr_inc(32'(wr_ptr_q), DEPTH));
    if (pop_i || overwrite_i) rd_ptr_d = PTR_W'(fx_ptr_inc(32'(rd_ptr_q), DEPTH));
    if (push_i && !overwrite_i && !pop_i) count_d = count_q + CNT_W'(1);
    else if (pop_i && !push_i)            count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Occupancy FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= OCC_EMPTY;
    else         state_q <= state_d;
  end

  // Occupancy FSM: next state follows the next count; DEPTH==1 never reaches PARTIAL
  always_comb begin
    state_d = OCC_PARTIAL;
    if (count_d == '0)                  state_d = OCC_EMPTY;
    else if (count_d == CNT_W'(DEPTH))  state_d = OCC_FULL;
  end

  // Occupancy FSM: outputs
  always_comb begin
    full_o  = (state_q == OCC_FULL);
    empty_o = (state_q == OCC_EMPTY);
  end

  assign head_o  = slot_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/frame_exchange.sv
// Game-to-VGA frame handoff: queues up to NUM_BUFFERS-1 frames and shows a swap-stable registered frame.
// Define FRAME_EXCHANGE_STATS_EN to add saturating dropped_frames/repeated_frames counters.
module frame_exchange
  import frame_exchange_pkg::*;
#(
  parameter int       FRAME_BITS  = 64,
  parameter int       NUM_BUFFERS = 3,
  parameter fx_mode_t MODE        = FX_NEWEST
) (
  input  logic                           HSOSC_clk,
  input  logic                           reset_n,
  frame_exchange_if.slave                fx,
  output logic [$clog2(NUM_BUFFERS)-1:0] frames_pending
`ifdef FRAME_EXCHANGE_STATS_EN
  ,
  output logic [15:0]                    dropped_frames,
  output logic [15:0]                    repeated_frames
`endif
);

  localparam int Q     = NUM_BUFFERS - 1;
  localparam int CNT_W = $clog2(NUM_BUFFERS);

  logic                  full, empty;
  logic                  pop_eff, push_wr, overwrite, refused;
  logic [FRAME_BITS-1:0] head;
  logic [FRAME_BITS-1:0] vga_q, vga_d;
  logic                  fresh_q, fresh_d;

  // A pop on a full queue frees the head slot this cycle, so a concurrent push is neither dropped nor refused.
  always_comb begin
    pop_eff   = fx.VGA_new_frame_ready && !empty;
    overwrite = fx.GAME_new_frame_ready && full && !pop_eff && (MODE == FX_NEWEST);
    refused   = fx.GAME_new_frame_ready && full && !pop_eff && (MODE == FX_HOLD);
    push_wr   = fx.GAME_new_frame_ready && !refused;
  end

  frame_ring #(
    .FRAME_BITS (FRAME_BITS),
    .DEPTH      (Q),
    .CNT_W      (CNT_W)
  ) u_ring (
    .clk_i       (HSOSC_clk),
    .rst_ni      (reset_n),
    .push_i      (push_wr),
    .pop_i       (pop_eff),
    .overwrite_i (overwrite),
    .din_i       (fx.GAME_next_frame),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (frames_pending)
  );

  always_comb begin
    vga_d   = pop_eff ? head : vga_q;
    fresh_d = pop_eff;
  end

  always_ff @(posedge HSOSC_clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_q   <= '0;
      fresh_q <= 1'b0;
    end else begin
      vga_q   <= vga_d;
      fresh_q <= fresh_d;
    end
  end

  assign fx.VGA_frame         = vga_q;
  assign fx.VGA_frame_fresh   = fresh_q;
  assign fx.GAME_frame_accept = (MODE == FX_HOLD) ? !full : 1'b1;

`ifdef FRAME_EXCHANGE_STATS_EN
  logic [15:0] dropped_q, dropped_d;
  logic [15:0] repeated_q, repeated_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    dropped_d  = sat_inc(dropped_q, overwrite || refused);
    repeated_d = sat_inc(repeated_q, fx.VGA_new_frame_ready && empty);
  end

  always_ff @(posedge HSOSC_clk or negedge reset_n) begin
    if (!reset_n) begin
      dropped_q  <= '0;
      repeated_q <= '0;
    end else begin
      dropped_q  <= dropped_d;
      repeated_q <= repeated_d;
    end
  end

  assign dropped_frames  = dropped_q;
  assign repeated_frames = repeated_q;
`endif

endmodule

// File: tb/tb_frame_exchange.sv
// Bench for frame_exchange: three instances (Q=2 newest-wins, Q=2 hold, Q=3 newest-wins) against a queue model.
// Directed scenarios first, then randomized push/pop traffic.
module tb_frame_exchange;
  import frame_exchange_pkg::*;

  logic HSOSC_clk;
  logic reset_n;

  initial HSOSC_clk = 1'b0;
  always #5 HSOSC_clk = ~HSOSC_clk;

  frame_exchange_if #(.FRAME_BITS(64)) fx0 ();
  frame_exchange_if #(.FRAME_BITS(64)) fx1 ();
  frame_exchange_if #(.FRAME_BITS(64)) fx2 ();

  bit          push_r [3];
  bit          pop_r  [3];
  logic [63:0] data_r [3];
  logic [1:0]  pend_w [3];
  logic [63:0] vga_w  [3];
  logic        fresh_w[3];
  logic        acc_w  [3];
`ifdef FRAME_EXCHANGE_STATS_EN
  logic [15:0] drop_w [3];
  logic [15:0] rep_w  [3];
`endif

  assign fx0.GAME_new_frame_ready = push_r[0];
  assign fx0.GAME_next_frame      = data_r[0];
  assign fx0.VGA_new_frame_ready  = pop_r[0];
  assign fx1.GAME_new_frame_ready = push_r[1];
  assign fx1.GAME_next_frame      = data_r[1];
  assign fx1.VGA_new_frame_ready  = pop_r[1];
  assign fx2.GAME_new_frame_ready = push_r[2];
  assign fx2.GAME_next_frame      = data_r[2];
  assign fx2.VGA_new_frame_ready  = pop_r[2];

  assign vga_w[0] = fx0.VGA_frame;  assign fresh_w[0] = fx0.VGA_frame_fresh;  assign acc_w[0] = fx0.GAME_frame_accept;
  assign vga_w[1] = fx1.VGA_frame;  assign fresh_w[1] = fx1.VGA_frame_fresh;  assign acc_w[1] = fx1.GAME_frame_accept;
  assign vga_w[2] = fx2.VGA_frame;  assign fresh_w[2] = fx2.VGA_frame_fresh;  assign acc_w[2] = fx2.GAME_frame_accept;

  frame_exchange #(.FRAME_BITS(64), .NUM_BUFFERS(3), .MODE(FX_NEWEST)) dut_newest (
    .HSOSC_clk (HSOSC_clk), .reset_n (reset_n), .fx (fx0), .frames_pending (pend_w[0])
`ifdef FRAME_EXCHANGE_STATS_EN
    , .dropped_frames (drop_w[0]), .repeated_frames (rep_w[0])
`endif
  );

  frame_exchange #(.FRAME_BITS(64), .NUM_BUFFERS(3), .MODE(FX_HOLD)) dut_hold (
    .HSOSC_clk (HSOSC_clk), .reset_n (reset_n), .fx (fx1), .frames_pending (pend_w[1])
`ifdef FRAME_EXCHANGE_STATS_EN
    , .dropped_frames (drop_w[1]), .repeated_frames (rep_w[1])
`endif
  );

  frame_exchange #(.FRAME_BITS(64), .NUM_BUFFERS(4), .MODE(FX_NEWEST)) dut_q3 (
    .HSOSC_clk (HSOSC_clk), .reset_n (reset_n), .fx (fx2), .frames_pending (pend_w[2])
`ifdef FRAME_EXCHANGE_STATS_EN
    , .dropped_frames (drop_w[2]), .repeated_frames (rep_w[2])
`endif
  );

  // Reference model: the queue itself, the displayed frame and event counters.
  localparam int QD [3]     = '{2, 2, 3};
  localparam bit IS_HOLD [3] = '{1'b0, 1'b1, 1'b0};

  logic [63:0] mq [3][$];
  logic [63:0] m_vga   [3];
  bit          m_fresh [3];
  int          m_drop  [3];
  int          m_rep   [3];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      m_vga[i]   = '0;
      m_fresh[i] = 1'b0;
      m_drop[i]  = 0;
      m_rep[i]   = 0;
    end
  endtask

  task automatic model_step(input int i);
    int pre;
    bit took;
    pre  = mq[i].size();
    took = pop_r[i] && (pre > 0);
    m_fresh[i] = took;
    if (took) m_vga[i] = mq[i].pop_front();
    if (pop_r[i] && pre == 0 && m_rep[i] < 65535) m_rep[i]++;
    if (push_r[i]) begin
      if (pre < QD[i] || took) begin
        mq[i].push_back(data_r[i]);
      end else if (!IS_HOLD[i]) begin
        void'(mq[i].pop_front());
        mq[i].push_back(data_r[i]);
        if (m_drop[i] < 65535) m_drop[i]++;
      end else begin
        if (m_drop[i] < 65535) m_drop[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("vga%0d", i),     vga_w[i],          m_vga[i]);
      chk($sformatf("fresh%0d", i),   64'(fresh_w[i]),   64'(m_fresh[i]));
      chk($sformatf("pending%0d", i), 64'(pend_w[i]),    64'(mq[i].size()));
      chk($sformatf("accept%0d", i),  64'(acc_w[i]),
          64'(IS_HOLD[i] ? (mq[i].size() < QD[i]) : 1'b1));
`ifdef FRAME_EXCHANGE_STATS_EN
      chk($sformatf("dropped%0d", i),  64'(drop_w[i]), 64'(m_drop[i]));
      chk($sformatf("repeated%0d", i), 64'(rep_w[i]),  64'(m_rep[i]));
`endif
    end
  endtask

  task automatic clear_strobes();
    for (int i = 0; i < 3; i++) begin
      push_r[i] = 1'b0;
      pop_r[i]  = 1'b0;
    end
  endtask

  // One clock: model consumes the driven strobes, DUTs sample them, then outputs are compared.
  task automatic tick();
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge HSOSC_clk);
    #1;
    check_all();
    clear_strobes();
  endtask

  task automatic push(input int i, input logic [63:0] d);
    push_r[i] = 1'b1;
    data_r[i] = d;
    tick();
  endtask

  task automatic pop(input int i);
    pop_r[i] = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    clear_strobes();
    for (int i = 0; i < 3; i++) data_r[i] = 64'hA5;
    model_reset();
    repeat (3) @(posedge HSOSC_clk);
    #1;
    reset_n = 1'b1;
    check_all();

    // Frame pushed after reset stays hidden until the pop, then shows one clock later.
    push(0, 64'hA5);
    chk("a5_before_pop", vga_w[0], 64'h0);
    pop(0);
    chk("a5_after_pop", vga_w[0], 64'hA5);
    chk("a5_fresh", 64'(fresh_w[0]), 64'd1);
    tick();
    chk("a5_fresh_drop", 64'(fresh_w[0]), 64'd0);

    // Newest-wins overflow drops frame 1.
    push(0, 64'd1);
    push(0, 64'd2);
    push(0, 64'd3);
    chk("newest_pending", 64'(pend_w[0]), 64'd2);
    pop(0);
    chk("newest_pop1", vga_w[0], 64'd2);
    pop(0);
    chk("newest_pop2", vga_w[0], 64'd3);

    // Hold mode refuses the third frame and repeats on an empty pop.
    push(1, 64'd1);
    push(1, 64'd2);
    chk("hold_accept_low", 64'(acc_w[1]), 64'd0);
    push(1, 64'd3);
    pop(1);
    chk("hold_pop1", vga_w[1], 64'd1);
    pop(1);
    chk("hold_pop2", vga_w[1], 64'd2);
    pop(1);
    chk("hold_repeat", vga_w[1], 64'd2);
    chk("hold_repeat_fresh", 64'(fresh_w[1]), 64'd0);

    // Empty queue, same-cycle push and pop: no bypass.
    push_r[0] = 1'b1;
    data_r[0] = 64'd7;
    pop(0);
    chk("empty_both_vga", vga_w[0], 64'd3);
    chk("empty_both_pending", 64'(pend_w[0]), 64'd1);
    pop(0);
    chk("empty_both_next", vga_w[0], 64'd7);

    // Full queue, same-cycle push and pop: head out, occupancy unchanged.
    push(0, 64'd8);
    push(0, 64'd10);
    push_r[0] = 1'b1;
    data_r[0] = 64'd9;
    pop(0);
    chk("full_both_vga", vga_w[0], 64'd8);
    chk("full_both_pending", 64'(pend_w[0]), 64'd2);

    // Depth 3: pointers wrap 2->0 while order is preserved.
    for (int k = 0; k < 10; k++) begin
      push(2, 64'(100 + k));
      pop(2);
      chk($sformatf("q3_order%0d", k), vga_w[2], 64'(100 + k));
    end
    push(2, 64'd200);
    push(2, 64'd201);
    push(2, 64'd202);
    pop(2);
    chk("q3_burst_head", vga_w[2], 64'd200);

    // Asynchronous reset mid-operation clears outputs without waiting for a clock.
    push(1, 64'h55);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_rst_vga%0d", i), vga_w[i], 64'h0);
      chk($sformatf("async_rst_pend%0d", i), 64'(pend_w[i]), 64'd0);
    end
    model_reset();
    @(posedge HSOSC_clk);
    #1;
    reset_n = 1'b1;
    check_all();
    pop(0);
    chk("post_rst_repeat", vga_w[0], 64'h0);

    // Randomized traffic on all three instances at once.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        push_r[i] = ($urandom_range(0, 99) < 55);
        pop_r[i]  = ($urandom_range(0, 99) < 40);
        data_r[i] = {$urandom, $urandom};
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_exchange.md
Name: frame_exchange

Overview:
- Parametrised successor to the fixed two-slot game/VGA frame handoff.
- Buffers up to NUM_BUFFERS game frames between the game encoder (producer) and the game decoder (consumer), all on one clock.
- Configurable overflow policy: newest-wins, or hold with backpressure.
- Presents a registered, swap-stable VGA_frame that changes only at the consumer's frame-boundary request.

Parameters:
- FRAME_BITS, 64: width of one packed frame (game_state_t bit width).
- NUM_BUFFERS, 3: total slots including the displayed one; legal range 2..5. Queue depth Q = NUM_BUFFERS-1.
- MODE, frame_exchange_pkg::FX_NEWEST: FX_NEWEST drops the oldest queued frame on overflow; FX_HOLD refuses pushes when full.

Ports:
- HSOSC_clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- GAME_new_frame_ready  input  1  single-cycle push strobe; GAME_next_frame is sampled this cycle.
- GAME_next_frame  input  FRAME_BITS  frame data from the producer.
- GAME_frame_accept  output  1  producer may push. Constant 1 in FX_NEWEST; equals (count<Q) in FX_HOLD.
- VGA_new_frame_ready  input  1  single-cycle pop request, issued at the start of v_sync.
- VGA_frame  output  FRAME_BITS  registered frame currently displayed.
- VGA_frame_fresh  output  1  one-cycle pulse in the cycle VGA_frame takes new content.
- frames_pending  output  $clog2(NUM_BUFFERS)  current queue occupancy (count).

Behaviour:
- Reset (async assert, sync release): count=0, rd_ptr=wr_ptr=0, VGA_frame='0, VGA_frame_fresh=0, GAME_frame_accept=1. Storage contents are don't-care.
- Queue: circular buffer of Q slots with rd_ptr/wr_ptr modulo Q. Explicit wrap from Q-1 to 0; Q need not be a power of two.
- Push, not full: slot[wr_ptr]<=GAME_next_frame, wr_ptr++, count++.
- Push while full, FX_NEWEST: overwrite slot[wr_ptr], advance wr_ptr and rd_ptr together, count unchanged. Oldest frame dropped.
- Push while full, FX_HOLD: push ignored, all state unchanged, frame lost (producer violated accept).
- Pop with count>0: VGA_frame<=slot[rd_ptr], rd_ptr++, count--, VGA_frame_fresh=1 next cycle. Latency is 1 clock from request to new VGA_frame.
- Pop with count==0: VGA_frame holds (repeat frame), VGA_frame_fresh=0.
- Simultaneous push and pop: both evaluate pre-cycle state.
  - Empty: no bypass. Push enqueues, pop repeats, count becomes 1.
  - Full, either mode: pop takes head, push enqueues, count unchanged, no drop, no refusal.
  - Otherwise: count unchanged.
- Occupancy state machine on count: EMPTY (0) <-> PARTIAL (1..Q-1) <-> FULL (Q). Q=1 has no PARTIAL state.
- Strobes held high for more than 1 cycle act as one event per cycle. No edge detection; callers guarantee pulses.
- Reset asserted mid-operation discards all queued frames and clears VGA_frame immediately.

Optional Feature:
- Macro FRAME_EXCHANGE_STATS_EN.
- Defined: adds two outputs, dropped_frames[15:0] and repeated_frames[15:0], saturating at 16'hFFFF, reset to 0.
  - dropped_frames increments on an FX_NEWEST overwrite or an FX_HOLD refused push.
  - repeated_frames increments on a pop with count==0.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- frame_exchange_pkg holds:
  - typedef enum logic {FX_NEWEST, FX_HOLD} fx_mode_t;
  - FX_MAX_BUFFERS=5;
  - a function for the modulo-Q pointer increment.
- Sub-module frame_ring: storage array, pointers, count. Its inputs are push/pop/overwrite, its outputs are head data/full/empty.
- frame_exchange adds policy, the output register, fresh pulse and stats.

Test Plan:
- Reset with GAME_next_frame=64'hA5 pushed, then pop: VGA_frame=0 until the pop, then 64'hA5 one clock later with fresh=1 for 1 cycle.
- NUM_BUFFERS=3, FX_NEWEST: push 1,2,3 with no pop, then pop twice -> VGA_frame 2 then 3. dropped_frames=1 when stats are enabled.
- FX_HOLD: push 1,2, accept=0, push 3 ignored, pop, pop -> 1,2. A third pop repeats 2 with fresh=0 and repeated_frames=1.
- Empty queue, push 7 and pop in the same cycle: VGA_frame unchanged, frames_pending=1. Next pop yields 7.
- Full queue with simultaneous push 9 and pop: head is output, frames_pending stays 2, no drop counted.
- NUM_BUFFERS=4 (Q=3): 10 pushes interleaved with 10 pops. Pointers wrap 2->0 and the output order matches the push order.
